sd_sector_arbiter: RTL and testbench
====================================

# sd_sector_arbiter

Shares the single sector channel of the MiST user_io SD-card emulation interface between two core-side requesters, for example two virtual drives. The block runs in the core clock domain. It selects one pending read or write per transfer using round-robin arbitration and drives `sd_lba`, `sd_rd` and `sd_wr`. It synchronises the SPI-domain `sd_ack` and strobe signals, streams the 512 sector bytes between user_io and the granted requester's buffer, and reports completion, errors and timeouts.

## Interface
- `TIMEOUT_BITS`, default 24: width of the watchdog counter. A timeout fires after 2^TIMEOUT_BITS−1 idle cycles.

- `clk` in 1: core clock, ≥4× SPI_CLK.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_rd` in 2: per-requester sector read request. Level; held until `done`/`err`.
- `req_wr` in 2: per-requester sector write request. Ignored for a requester whose `req_rd` is also high.
- `req_lba0`, `req_lba1` in 32 each: sector address. Stable while the request is high.
- `req_din0`, `req_din1` in 8 each: write data for byte `buf_addr`.
- `grant` out 2: one-hot owner of the current transfer.
- `done` out 2: one-cycle pulse on successful completion.
- `err` out 2: one-cycle pulse on a short transfer or a timeout.
- `buf_addr` out 9: byte index within the sector.
- `buf_dout` out 8: read byte.
- `buf_we` out 1: one-cycle write strobe for `buf_dout` at `buf_addr`.
- `sd_lba` out 32: to user_io.
- `sd_rd` out 1: to user_io.
- `sd_wr` out 1: to user_io.
- `sd_ack` in 1: from user_io, SPI domain.
- `sd_dout` in 8: from user_io, SPI domain.
- `sd_dout_strobe` in 1: from user_io, SPI domain.
- `sd_din` out 8: to user_io. Equals `req_din[g]` for the granted requester g; 0 when `grant`=0.
- `sd_din_strobe` in 1: from user_io, SPI domain.

## Operation
- **Synchronisers:** `sd_ack`, `sd_dout_strobe` and `sd_din_strobe` each pass through a 2-FF synchroniser followed by an edge detector. `ack_r`/`ack_f` are the rise/fall of `sd_ack`; `dstb`/`istb` are the rising edges of the dout/din strobes.
- **Data capture:** `sd_dout` is sampled in the cycle `dstb` is detected. The byte is stable for ≥7 SPI clocks, so it is not synchronised.
- **Arbitration:** round-robin pointer `last`, reset value 1, so requester 0 wins the first tie. In IDLE, requester i is pending if `req_rd[i]|req_wr[i]`. With both pending, the grant goes to `~last`; otherwise it goes to the sole pending requester.
- **State machine:** IDLE → ISSUE → XFER → IDLE.
  - **IDLE:** on a pending request, latch `grant`, `last`, the direction (rd wins over wr) and `sd_lba` ← `req_lbaN`. Clear `buf_addr`, the byte counter `cnt` (10 bit) and the watchdog. Assert `sd_rd` or `sd_wr`. Go to ISSUE.
  - **ISSUE:** on `ack_r`, deassert `sd_rd`/`sd_wr` and go to XFER.
  - **XFER, read:** each `dstb` writes `buf_dout` ← `sd_dout`, pulses `buf_we` with the current `buf_addr`, then increments `cnt` and `buf_addr`. `buf_addr` saturates at 511.
  - **XFER, write:** each `istb` increments `cnt` and `buf_addr` (saturating). The first `istb` arrives on the command byte itself and fetches byte 0, so a full sector gives 513 `istb`. Only `cnt`≥512 is checked.
  - **XFER exit:** on `ack_f`, pulse `done[g]` if `cnt`≥512, else pulse `err[g]`. Clear `grant` and return to IDLE.
- **Watchdog:** resets on state entry and on every `ack_r`/`dstb`/`istb`. It counts in ISSUE and XFER. On all-ones: pulse `err[g]`, drop `sd_rd`/`sd_wr`/`grant`, and return to IDLE.
- **Request changes:** a requester dropping its request mid-transfer does not abort. The transfer completes and `done`/`err` is still pulsed.
- **Back-to-back requests:** a requester that keeps its request high after `done` is re-arbitrated from IDLE. If both requesters are pending, it loses to the other.
- **Reset values:** `grant`, `done`, `err`, `buf_we`, `sd_rd` and `sd_wr` are 0. `sd_lba`, `buf_addr` and `buf_dout` are 0. State is IDLE. Asserting reset mid-transfer abandons the transfer silently; requesters must reissue.

## Timing
- Request high in IDLE → `grant`, `sd_lba` and `sd_rd`/`sd_wr` valid on the next clock edge.
- `sd_ack` rise → `sd_rd`/`sd_wr` low 3 clk later: 2 synchroniser stages plus 1 edge-detect stage.
- `sd_dout_strobe` rise → `buf_we` pulse 3 clk later. `buf_addr`/`buf_dout` are valid in the same cycle as `buf_we`. `buf_addr` increments one clk after `buf_we`.
- `istb` → `buf_addr` increments 1 clk later. The requester must present `req_din` within 2 clk of a `buf_addr` change, so that `sd_din` is settled before the next SPI byte is sampled.
- `sd_ack` fall → `done`/`err` pulse 3 clk later. IDLE is re-entered in the same cycle, and a new grant is possible on the following clock.
- `done`, `err` and `buf_we` are exactly one clk wide. At most one bit of `grant`/`done`/`err` is ever set.

## Test plan
- **Single read:**
  - Stimulus: `req_rd`=01, `req_lba0`=0x00001234. The user_io model raises `sd_ack`, sends bytes 0x00..0xFF twice, then drops `sd_ack`.
  - Response: `sd_lba`=0x1234. `sd_rd` rises 1 clk after the request and falls 3 clk after ack. There are 512 `buf_we` pulses with `buf_addr`=n and `buf_dout`=n&0xFF. `done`=01, `err`=00.
- **Write:**
  - Stimulus: `req_wr`=10. The requester returns `req_din1` = `buf_addr`[7:0]^0xA5. The model issues 513 `sd_din_strobe`.
  - Response: the model captures 0xA5, 0xA4, … for 512 bytes. `sd_wr` is high until ack. `done`=10.
- **Contention:**
  - Stimulus: `req_rd`=11 held continuously across three transfers.
  - Response: the grant sequence is 01, 10, 01.
- **Short read:**
  - Stimulus: the model drops `sd_ack` after 100 bytes.
  - Response: `err`=01, `done`=00, and 100 `buf_we` pulses.
- **Timeout and reset:**
  - Timeout stimulus: with `TIMEOUT_BITS`=6, `sd_ack` never rises. Response: `err` pulses 63 clk after ISSUE entry, and `sd_rd`=0.
  - Reset stimulus: pulse `reset_n` low mid-XFER. Response: all outputs are 0 immediately and the block is in IDLE.

Source files
------------

// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter
// Shares the single sector channel of the user_io SD-card emulation between
// two core-side requesters. Each transfer goes to one pending requester,
// chosen round-robin. The block synchronises the SPI-domain handshake and
// strobes, streams the 512 sector bytes and reports done/err per requester.
//
// State table:
//   IDLE  | no transfer; arbitrate pending requests
//   ISSUE | sd_rd/sd_wr asserted, waiting for sd_ack to rise
//   XFER  | streaming bytes, waiting for sd_ack to fall
//
// Ports:
//   clk, reset_n            core clock, async active-low reset
//   req_rd/req_wr [1:0]     per-requester read/write request levels
//   req_lba0/1             sector address per requester
//   req_din0/1             write data for byte buf_addr per requester
//   grant/done/err [1:0]    one-hot owner, completion and error pulses
//   buf_addr/buf_dout/buf_we  requester buffer port
//   sd_lba/sd_rd/sd_wr      command to user_io
//   sd_ack/sd_dout/sd_dout_strobe/sd_din_strobe  from user_io (SPI domain)
//   sd_din                  write byte to user_io from the granted requester
module sd_sector_arbiter #(
    parameter int TIMEOUT_BITS = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [31:0] req_lba0,
    input  logic [31:0] req_lba1,
    input  logic [7:0]  req_din0,
    input  logic [7:0]  req_din1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [8:0]  buf_addr,
    output logic [7:0]  buf_dout,
    output logic        buf_we,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [7:0]  sd_dout,
    input  logic        sd_dout_strobe,
    output logic [7:0]  sd_din,
    input  logic        sd_din_strobe
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    // Bits [1:0] form the 2-FF synchroniser, bit [2] holds the previous
    // synchronised value for edge detection.
    logic [2:0] ack_q, dstb_q, istb_q;
    logic       ack_r, ack_f, dstb, istb, activity;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q  <= '0;
            dstb_q <= '0;
            istb_q <= '0;
        end else begin
            ack_q  <= {ack_q[1:0], sd_ack};
            dstb_q <= {dstb_q[1:0], sd_dout_strobe};
            istb_q <= {istb_q[1:0], sd_din_strobe};
        end
    end

    assign ack_r    = ack_q[1] & ~ack_q[2];
    assign ack_f    = ~ack_q[1] & ack_q[2];
    assign dstb     = dstb_q[1] & ~dstb_q[2];
    assign istb     = istb_q[1] & ~istb_q[2];
    assign activity = ack_r | dstb | istb;

    state_t                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic [1:0]              done_q, done_d;
    logic [1:0]              err_q, err_d;
    logic                    last_q, last_d;
    logic                    is_rd_q, is_rd_d;
    logic [31:0]             lba_q, lba_d;
    logic                    sd_rd_q, sd_rd_d;
    logic                    sd_wr_q, sd_wr_d;
    logic [8:0]              buf_addr_q, buf_addr_d;
    logic [7:0]              buf_dout_q, buf_dout_d;
    logic                    buf_we_q, buf_we_d;
    logic [9:0]              cnt_q, cnt_d;
    logic [TIMEOUT_BITS-1:0] wd_q, wd_d;

    logic [1:0] pending;
    logic       win;
    logic       wd_tc;
    logic       step;

    assign pending = req_rd | req_wr;
    // On a tie the requester that did not own the previous transfer wins.
    assign win     = (pending == 2'b11) ? ~last_q : pending[1];
    // Down-counter reloaded with all-ones; the step from 1 to 0 completes
    // 2^TIMEOUT_BITS-1 idle cycles.
    assign wd_tc   = (wd_q == TIMEOUT_BITS'(1));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = 2'b00;
        err_d      = 2'b00;
        last_d     = last_q;
        is_rd_d    = is_rd_q;
        lba_d      = lba_q;
        sd_rd_d    = sd_rd_q;
        sd_wr_d    = sd_wr_q;
        buf_addr_d = buf_addr_q;
        buf_dout_d = buf_dout_q;
        buf_we_d   = 1'b0;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        step       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending != 2'b00) begin
                    grant_d    = win ? 2'b10 : 2'b01;
                    last_d     = win;
                    is_rd_d    = req_rd[win];
                    lba_d      = win ? req_lba1 : req_lba0;
                    sd_rd_d    = req_rd[win];
                    sd_wr_d    = ~req_rd[win];
                    buf_addr_d = 9'd0;
                    cnt_d      = 10'd0;
                    wd_d       = '1;
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (ack_r) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    wd_d    = '1;
                    state_d = ST_XFER;
                end else if (wd_tc) begin
                    err_d   = grant_q;
                    grant_d = 2'b00;
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q - TIMEOUT_BITS'(1);
                end
            end

            ST_XFER: begin
                if (is_rd_q) begin
                    if (dstb) begin
                        buf_we_d   = 1'b1;
                        buf_dout_d = sd_dout;
                    end
                    // Address advances the cycle after the write strobe so
                    // buf_addr is valid alongside buf_we.
                    step = buf_we_q;
                end else begin
                    step = istb;
                end

                if (step) begin
                    if (cnt_q != 10'h3FF) begin
                        cnt_d = cnt_q + 10'd1;
                    end
                    if (buf_addr_q != 9'd511) begin
                        buf_addr_d = buf_addr_q + 9'd1;
                    end
                end

                if (ack_f) begin
                    if (cnt_q >= 10'd512) begin
                        done_d = grant_q;
                    end else begin
                        err_d = grant_q;
                    end
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end else if (activity) begin
                    wd_d = '1;
                end else if (wd_tc) begin
                    err_d   = grant_q;
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q - TIMEOUT_BITS'(1);
                end
            end

            default: begin
                grant_d = 2'b00;
                sd_rd_d = 1'b0;
                sd_wr_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            last_q     <= 1'b1;
            is_rd_q    <= 1'b0;
            lba_q      <= 32'd0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            buf_addr_q <= 9'd0;
            buf_dout_q <= 8'd0;
            buf_we_q   <= 1'b0;
            cnt_q      <= 10'd0;
            wd_q       <= '1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
            last_q     <= last_d;
            is_rd_q    <= is_rd_d;
            lba_q      <= lba_d;
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            buf_addr_q <= buf_addr_d;
            buf_dout_q <= buf_dout_d;
            buf_we_q   <= buf_we_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
        end
    end

    always_comb begin
        sd_din = 8'h00;
        if (grant_q[0]) begin
            sd_din = req_din0;
        end else if (grant_q[1]) begin
            sd_din = req_din1;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign err      = err_q;
    assign buf_addr = buf_addr_q;
    assign buf_dout = buf_dout_q;
    assign buf_we   = buf_we_q;
    assign sd_lba   = lba_q;
    assign sd_rd    = sd_rd_q;
    assign sd_wr    = sd_wr_q;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Testbench for sd_sector_arbiter: a user_io host model and two requester
// models drive the block; a reference model predicts grants, commands,
// buffer writes, captured write bytes and completion status.
module tb_sd_sector_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_rd, req_wr;
    logic [31:0] req_lba0, req_lba1;
    logic [7:0]  req_din0, req_din1;
    logic [1:0]  grant, done, err;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_dout;
    logic        buf_we;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [7:0]  sd_dout;
    logic        sd_dout_strobe;
    logic [7:0]  sd_din;
    logic        sd_din_strobe;

    int checks   = 0;
    int failures = 0;

    logic [16:0] we_log[$];
    logic [7:0]  wr_cap[$];
    logic [7:0]  rd_data[$];
    int          model_last = 1;
    logic [1:0]  last_grant_seen;
    logic        we_prev = 1'b0;
    logic [1:0]  de_prev = 2'b00;

    sd_sector_arbiter #(.TIMEOUT_BITS(6)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_rd         (req_rd),
        .req_wr         (req_wr),
        .req_lba0       (req_lba0),
        .req_lba1       (req_lba1),
        .req_din0       (req_din0),
        .req_din1       (req_din1),
        .grant          (grant),
        .done           (done),
        .err            (err),
        .buf_addr       (buf_addr),
        .buf_dout       (buf_dout),
        .buf_we         (buf_we),
        .sd_lba         (sd_lba),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .sd_ack         (sd_ack),
        .sd_dout        (sd_dout),
        .sd_dout_strobe (sd_dout_strobe),
        .sd_din         (sd_din),
        .sd_din_strobe  (sd_din_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Requesters serve their buffers: byte n of requester 0 is n^0x3C,
    // of requester 1 is n^0xA5.
    always @(negedge clk) begin
        req_din0 = buf_addr[7:0] ^ 8'h3C;
        req_din1 = buf_addr[7:0] ^ 8'hA5;
    end

    always @(negedge clk) begin
        if (buf_we) begin
            we_log.push_back({buf_addr, buf_dout});
            check("we_width", {63'd0, we_prev}, 64'd0);
        end
        if ((done | err) != 2'b00) begin
            check("pulse_width", {62'd0, de_prev}, 64'd0);
            check("pulse_onehot", {63'd0, $onehot(done | err)}, 64'd1);
        end
        if (grant != 2'b00) begin
            check("grant_onehot", {63'd0, $onehot(grant)}, 64'd1);
        end
        we_prev = buf_we;
        de_prev = done | err;
    end

    function automatic int pick(input logic [1:0] pend, input int last);
        if (pend == 2'b11) return 1 - last;
        return pend[1] ? 1 : 0;
    endfunction

    task automatic send_read_byte(input logic [7:0] b);
        sd_dout = b;
        @(negedge clk);
        sd_dout_strobe = 1'b1;
        repeat (3) @(negedge clk);
        sd_dout_strobe = 1'b0;
    endtask

    // Runs one complete transfer for the currently asserted requests.
    // Must be called at a negedge while the block is idle.
    task automatic run_xfer(input int nbytes, input bit fixed_data);
        int         g, n;
        bit         exp_rd, full;
        logic [1:0] exp_g;
        logic [31:0] exp_lba;
        logic [7:0] key, b;
        g       = pick(req_rd | req_wr, model_last);
        model_last = g;
        exp_g   = (g == 1) ? 2'b10 : 2'b01;
        exp_rd  = req_rd[g];
        exp_lba = (g == 1) ? req_lba1 : req_lba0;
        key     = (g == 1) ? 8'hA5 : 8'h3C;
        full    = (nbytes >= 512);
        we_log.delete();
        wr_cap.delete();
        rd_data.delete();

        n = 0;
        do begin @(negedge clk); n++; end while (!(sd_rd || sd_wr) && n < 20);
        check("issue_latency", n, 1);
        last_grant_seen = grant;
        check("grant", grant, exp_g);
        check("sd_lba", sd_lba, exp_lba);
        check("sd_rd", sd_rd, exp_rd);
        check("sd_wr", sd_wr, !exp_rd);

        repeat ($urandom_range(1, 10)) @(negedge clk);
        check("cmd_held", {sd_rd, sd_wr}, {exp_rd, !exp_rd});
        sd_ack = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while ((sd_rd || sd_wr) && n < 20);
        check("ack_to_cmd_low", n, 3);

        repeat ($urandom_range(2, 10)) @(negedge clk);
        for (int i = 0; i < nbytes; i++) begin
            if (exp_rd) begin
                b = fixed_data ? 8'(i) : 8'($urandom);
                rd_data.push_back(b);
                send_read_byte(b);
            end else begin
                wr_cap.push_back(sd_din);
                sd_din_strobe = 1'b1;
                repeat (3) @(negedge clk);
                sd_din_strobe = 1'b0;
            end
            repeat ($urandom_range(8, 14)) @(negedge clk);
        end

        repeat ($urandom_range(2, 10)) @(negedge clk);
        sd_ack = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while ((done | err) == 2'b00 && n < 20);
        check("ackf_to_status", n, 3);
        check("done", done, full ? exp_g : 2'b00);
        check("err", err, full ? 2'b00 : exp_g);
        check("grant_released", grant, 2'b00);

        if (exp_rd) begin
            check("we_count", we_log.size(), nbytes);
            for (int i = 0; i < we_log.size() && i < nbytes; i++) begin
                check("we_addr", we_log[i][16:8], (i > 511) ? 511 : i);
                check("we_data", we_log[i][7:0], rd_data[i]);
            end
        end else begin
            check("wr_no_we", we_log.size(), 0);
            for (int i = 0; i < nbytes && i < 512; i++) begin
                check("wr_byte", wr_cap[i], key ^ 8'(i));
            end
        end
    endtask

    initial begin
        int          n;
        logic [1:0]  rr, ww;
        logic [1:0]  seq [3];
        seq[0] = 2'b01;
        seq[1] = 2'b10;
        seq[2] = 2'b01;

        reset_n = 1'b0;
        req_rd = 2'b00;
        req_wr = 2'b00;
        req_lba0 = 32'd0;
        req_lba1 = 32'd0;
        sd_ack = 1'b0;
        sd_dout = 8'd0;
        sd_dout_strobe = 1'b0;
        sd_din_strobe = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", {grant, done, err, buf_we, sd_rd, sd_wr}, 0);
        check("rst_lba", sd_lba, 0);
        check("rst_buf", {buf_addr, buf_dout, sd_din}, 0);
        reset_n = 1'b1;

        // Single full read, bytes 0x00..0xFF twice.
        req_rd = 2'b01;
        req_lba0 = 32'h0000_1234;
        run_xfer(512, 1'b1);
        req_rd = 2'b00;

        // Full write from requester 1: 513 din strobes.
        req_wr = 2'b10;
        req_lba1 = $urandom;
        run_xfer(513, 1'b0);
        req_wr = 2'b00;

        // Short read: 100 bytes then ack drops.
        req_rd = 2'b01;
        req_lba0 = $urandom;
        run_xfer(100, 1'b0);
        req_rd = 2'b00;

        // Timeout: ack never rises.
        req_rd = 2'b01;
        req_lba0 = $urandom;
        model_last = pick(req_rd, model_last);
        n = 0;
        do begin @(negedge clk); n++; end while (!sd_rd && n < 20);
        check("to_issue_latency", n, 1);
        check("to_grant", grant, 2'b01);
        n = 0;
        do begin @(negedge clk); n++; end while (err == 2'b00 && n < 200);
        check("to_latency", n, 63);
        check("to_err", err, 2'b01);
        check("to_done", done, 2'b00);
        check("to_cmd_low", {sd_rd, sd_wr}, 2'b00);
        check("to_grant_low", grant, 2'b00);
        req_rd = 2'b00;

        // Reset in the middle of a read transfer.
        req_rd = 2'b10;
        req_lba1 = $urandom;
        n = 0;
        do begin @(negedge clk); n++; end while (!sd_rd && n < 20);
        check("mid_issue_latency", n, 1);
        sd_ack = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            send_read_byte(8'($urandom));
            repeat (10) @(negedge clk);
        end
        check("pre_rst_addr", buf_addr, 10);
        check("pre_rst_grant", grant, 2'b10);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_outs", {grant, done, err, buf_we, sd_rd, sd_wr}, 0);
        check("mid_rst_lba", sd_lba, 0);
        check("mid_rst_buf", {buf_addr, buf_dout, sd_din}, 0);
        sd_ack = 1'b0;
        req_rd = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        model_last = 1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {grant, sd_rd, sd_wr, done, err}, 0);

        // Contention: both requesters held across three transfers.
        req_rd = 2'b11;
        req_lba0 = $urandom;
        req_lba1 = $urandom;
        for (int k = 0; k < 3; k++) begin
            run_xfer($urandom_range(5, 30), 1'b0);
            check("contention_seq", last_grant_seen, seq[k]);
        end
        req_rd = 2'b00;

        // Read wins over write for the same requester.
        req_rd = 2'b01;
        req_wr = 2'b01;
        req_lba0 = $urandom;
        run_xfer($urandom_range(1, 20), 1'b0);
        req_rd = 2'b00;
        req_wr = 2'b00;

        // Randomised request mixes.
        for (int k = 0; k < 8; k++) begin
            do begin
                rr = 2'($urandom);
                ww = 2'($urandom);
            end while ((rr | ww) == 2'b00);
            req_rd = rr;
            req_wr = ww;
            req_lba0 = $urandom;
            req_lba1 = $urandom;
            run_xfer($urandom_range(1, 40), 1'b0);
            req_rd = 2'b00;
            req_wr = 2'b00;
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
